// File: rtl/shared_res_pkg.sv
// -----------------------------------------------------------------------------
// shared_res_pkg
//
// Purpose : Shared types and helpers for the shared-resource controller.
//           Holds the controller state encoding and the width helper used to
//           size requester ids and the internal counters.
//
// Contents:
//   ctrl_state_t : OFF / WARMUP / READY / BUSY controller states
//   id_width()   : max(1, $clog2(n)), used for id and counter widths
// -----------------------------------------------------------------------------
package shared_res_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        WARMUP = 2'd1,
        READY  = 2'd2,
        BUSY   = 2'd3
    } ctrl_state_t;

    // $clog2 returns 0 for n<=1; every field needs at least one bit.
    function automatic int id_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : shared_res_pkg

// File: rtl/shared_res_ctrl_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purpose : Combinational round-robin picker. The search starts at the
//           requester after last_id and ascends with wrap-around; the first
//           asserted request wins. A lone requester equal to last_id is picked
//           again because the search wraps all the way back to it.
//
// Ports:
//   req     in  [N_REQ-1:0] request vector
//   last_id in  [IDW-1:0]   index of the most recently released grantee
//   valid   out             at least one request is asserted
//   pick    out [IDW-1:0]   winning requester index (0 when !valid)
// -----------------------------------------------------------------------------
module rr_pick
    import shared_res_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = id_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDW-1:0]   last_id,
    output logic             valid,
    output logic [IDW-1:0]   pick
);

    // Two spare bits so last_id + N_REQ never overflows before the wrap.
    localparam int SW = IDW + 2;

    // rot[k] is the request of the requester k+1 positions after last_id;
    // slot_id[k] is that requester's absolute index.
    logic [N_REQ-1:0] rot;
    logic [IDW-1:0]   slot_id [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_slot
            logic [SW-1:0] sum;

            // last_id < N_REQ and gi+1 <= N_REQ, so a single subtract wraps.
            assign sum         = {2'b00, last_id} + SW'(gi + 1);
            assign slot_id[gi] = (sum >= SW'(N_REQ)) ? IDW'(sum - SW'(N_REQ))
                                                     : IDW'(sum);
            assign rot[gi]     = req[slot_id[gi]];
        end
    endgenerate

    // Scan from the far end so the nearest asserted slot overwrites the rest.
    always_comb begin
        valid = 1'b0;
        pick  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                valid = 1'b1;
                pick  = slot_id[k];
            end
        end
    end

endmodule : rr_pick

// File: rtl/shared_res_ctrl.sv
// -----------------------------------------------------------------------------
// shared_res_ctrl
//
// Purpose : Arbitrates N_REQ requesters onto a single ON/OFF resource. Powers
//           the resource up on the first request, waits WARMUP_CYC cycles,
//           then hands out round-robin grants limited to MAX_HOLD cycles each.
//           After IDLE_CYC request-free cycles in READY the resource is
//           switched off again.
//
// Ports:
//   clk    in                 system clock, rising edge
//   rst    in                 asynchronous active-high reset
//   req    in  [N_REQ-1:0]    level requests, held until granted and finished
//   gnt    out [N_REQ-1:0]    one-hot grant (registered)
//   gnt_id out [IDW-1:0]      index of the current grantee, 0 when idle
//   res_on out                resource enable (registered)
//   busy   out                high while the controller is in BUSY
// -----------------------------------------------------------------------------
module shared_res_ctrl
    import shared_res_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int WARMUP_CYC = 3,
    parameter int IDLE_CYC   = 8,
    parameter int MAX_HOLD   = 16,
    parameter int IDW        = id_width(N_REQ)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [IDW-1:0]   gnt_id,
    output logic             res_on,
    output logic             busy
);

    localparam int WW = id_width(WARMUP_CYC);
    localparam int IW = id_width(IDLE_CYC);
    localparam int HW = id_width(MAX_HOLD);

    localparam logic [WW-1:0]    WCNT_LOAD = WW'(WARMUP_CYC - 1);
    localparam logic [IW-1:0]    ICNT_LAST = IW'(IDLE_CYC - 1);
    localparam logic [HW-1:0]    HCNT_LAST = HW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0]   LAST_RST  = IDW'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

    // Registered state and outputs
    ctrl_state_t      state_q,  state_d;
    logic [WW-1:0]    wcnt_q,   wcnt_d;
    logic [IW-1:0]    icnt_q,   icnt_d;
    logic [HW-1:0]    hcnt_q,   hcnt_d;
    logic [IDW-1:0]   last_id_q, last_id_d;
    logic [N_REQ-1:0] gnt_q,    gnt_d;
    logic [IDW-1:0]   gnt_id_q, gnt_id_d;
    logic             res_on_q, res_on_d;
    logic             busy_q,   busy_d;

    // Round-robin arbitration
    logic             pick_valid;
    logic [IDW-1:0]   pick_id;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDW   (IDW)
    ) u_rr_pick (
        .req     (req),
        .last_id (last_id_q),
        .valid   (pick_valid),
        .pick    (pick_id)
    );

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        wcnt_d    = wcnt_q;
        icnt_d    = icnt_q;
        hcnt_d    = hcnt_q;
        last_id_d = last_id_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        res_on_d  = res_on_q;

        unique case (state_q)
            OFF: begin
                res_on_d = 1'b0;
                if (|req) begin
                    state_d  = WARMUP;
                    res_on_d = 1'b1;
                    wcnt_d   = WCNT_LOAD;
                end
            end

            // Warm-up runs to completion regardless of what req does.
            WARMUP: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    state_d = READY;
                    icnt_d  = '0;
                end
            end

            // A pending request always beats idle expiry on the same edge.
            READY: begin
                gnt_d    = '0;
                gnt_id_d = '0;
                if (pick_valid) begin
                    state_d  = BUSY;
                    gnt_d    = ONE_HOT0 << pick_id;
                    gnt_id_d = pick_id;
                    hcnt_d   = '0;
                    icnt_d   = '0;
                end else if (icnt_q == ICNT_LAST) begin
                    state_d  = OFF;
                    res_on_d = 1'b0;
                    icnt_d   = '0;
                end else begin
                    icnt_d = icnt_q + 1'b1;
                end
            end

            // Voluntary release and hold expiry share one exit path, so
            // both firing together is still a single move to READY.
            BUSY: begin
                if (!req[gnt_id_q] || (hcnt_q == HCNT_LAST)) begin
                    state_d   = READY;
                    gnt_d     = '0;
                    gnt_id_d  = '0;
                    last_id_d = gnt_id_q;
                    hcnt_d    = '0;
                end else begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end

            default: begin
                state_d  = OFF;
                gnt_d    = '0;
                gnt_id_d = '0;
                res_on_d = 1'b0;
            end
        endcase

        busy_d = (state_d == BUSY);
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= OFF;
            wcnt_q    <= '0;
            icnt_q    <= '0;
            hcnt_q    <= '0;
            last_id_q <= LAST_RST;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            res_on_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            icnt_q    <= icnt_d;
            hcnt_q    <= hcnt_d;
            last_id_q <= last_id_d;
            gnt_q     <= gnt_d;
            gnt_id_q  <= gnt_id_d;
            res_on_q  <= res_on_d;
            busy_q    <= busy_d;
        end
    end

    assign gnt    = gnt_q;
    assign gnt_id = gnt_id_q;
    assign res_on = res_on_q;
    assign busy   = busy_q;

endmodule : shared_res_ctrl

// File: tb/tb_shared_res_ctrl.sv
// -----------------------------------------------------------------------------
// tb_shared_res_ctrl
//
// Directed bench for shared_res_ctrl with default parameters (N_REQ=4,
// WARMUP_CYC=3, IDLE_CYC=8, MAX_HOLD=16). Inputs change and outputs are
// sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_shared_res_ctrl;

    localparam int N_REQ = 4;

    logic             clk;
    logic             rst;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [1:0]       gnt_id;
    logic             res_on;
    logic             busy;

    int n_checks;
    int n_pass;

    shared_res_ctrl #(
        .N_REQ      (4),
        .WARMUP_CYC (3),
        .IDLE_CYC   (8),
        .MAX_HOLD   (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .gnt    (gnt),
        .gnt_id (gnt_id),
        .res_on (res_on),
        .busy   (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end else begin
            n_pass++;
            $display("ok   %s: 0x%0h (t=%0t)", tag, obs, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Safety net against a stuck run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int exp_order[5];
        int n;
        int gnt_seen;
        int res_low;

        exp_order = '{0, 1, 2, 3, 0};
        n_checks  = 0;
        n_pass    = 0;
        rst       = 1'b1;
        req       = '0;

        // Reset state
        tick();
        tick();
        check("rst_gnt",    gnt,    0);
        check("rst_gnt_id", gnt_id, 0);
        check("rst_res_on", res_on, 0);
        check("rst_busy",   busy,   0);

        // Cold start: req=0100 before E0
        rst = 1'b0;
        req = 4'b0100;
        tick();                                   // E0
        check("cold_res_on_e0", res_on, 1);
        check("cold_gnt_e0",    gnt,    0);
        repeat (3) tick();                        // E3
        check("cold_gnt_e3",    gnt,    0);
        check("cold_busy_e3",   busy,   0);
        tick();                                   // E4
        check("cold_gnt_e4",    gnt,    4'b0100);
        check("cold_gnt_id_e4", gnt_id, 2);
        check("cold_busy_e4",   busy,   1);

        // Release, then idle power-down after 8 request-free READY edges
        req = '0;
        tick();
        check("rel_gnt",  gnt,    0);
        check("rel_busy", busy,   0);
        check("rel_id",   gnt_id, 0);
        repeat (7) tick();
        check("idle7_res_on", res_on, 1);
        tick();
        check("idle8_res_on", res_on, 0);

        // Cold start on requester 1, then async reset mid-grant
        req = 4'b0010;
        tick();
        check("c2_res_on_e0", res_on, 1);
        repeat (4) tick();
        check("c2_gnt_e4", gnt, 4'b0010);
        #2 rst = 1'b1;
        #1;
        check("arst_gnt",    gnt,    0);
        check("arst_gnt_id", gnt_id, 0);
        check("arst_res_on", res_on, 0);
        check("arst_busy",   busy,   0);
        tick();
        tick();
        rst = 1'b0;                               // req still 0010

        // Full warm-up repeats
        tick();                                   // E0
        check("c3_res_on_e0", res_on, 1);
        repeat (3) tick();                        // E3
        check("c3_gnt_e3", gnt, 0);
        tick();                                   // E4
        check("c3_gnt_e4", gnt, 4'b0010);

        // Release (last_id=1); request arriving on the 8th idle cycle wins
        req = '0;
        tick();
        repeat (7) tick();
        check("late_res_on7", res_on, 1);
        req = 4'b1000;
        tick();
        check("late_res_on8", res_on, 1);
        check("late_gnt",     gnt,    4'b1000);
        check("late_gnt_id",  gnt_id, 3);
        req = '0;
        tick();                                   // release, last_id=3
        check("late_rel_gnt", gnt, 0);

        // Fairness: all four request; each drops 2 cycles after its grant
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("rr_gnt%0d", i), gnt, 32'd1 << exp_order[i]);
            check($sformatf("rr_id%0d",  i), gnt_id, exp_order[i]);
            tick();
            req[exp_order[i]] = 1'b0;
            tick();
            check($sformatf("rr_gap%0d", i), gnt, 0);
            req[exp_order[i]] = 1'b1;
        end
        req = '0;
        tick();

        // Hold timeout: lone requester 1
        req = 4'b0010;
        tick();
        check("hold_first", gnt, 4'b0010);
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt == 4'b0010) n++;
            else break;
        end
        check("hold_len",  n,   16);
        check("hold_gap",  gnt, 0);
        tick();
        check("hold_regrant", gnt, 4'b0010);

        // Requester 2 joins during BUSY; it gets the next grant
        req = 4'b0110;
        n = 1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (gnt == 4'b0010) n++;
            else break;
        end
        check("hold_len2", n,   16);
        check("hold_gap2", gnt, 0);
        tick();
        check("hold_next",    gnt,    4'b0100);
        check("hold_next_id", gnt_id, 2);
        req = '0;
        tick();
        repeat (8) tick();
        check("hold_off", res_on, 0);

        // One-cycle request pulse: warm-up completes, then idle power-down
        req = 4'b0001;
        tick();                                   // E0
        check("pulse_res_on_e0", res_on, 1);
        req = '0;
        gnt_seen = 0;
        res_low  = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (gnt != 0) gnt_seen++;
            if (res_on == 1'b0) res_low++;
        end
        check("pulse_gnt_seen", gnt_seen, 0);
        check("pulse_res_low",  res_low,  0);
        tick();                                   // E11
        check("pulse_res_off",  res_on,   0);
        check("pulse_gnt_end",  gnt,      0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_shared_res_ctrl
